// File: rtl/simon_out_collector.sv
// simon_out_collector
//
// Bit-serial to byte-wide output stage for the SIMON 64/128 core.
// It collects one ciphertext block LSB-first, then drains it as bytes
// over a valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears all state
//   bit_in      serial ciphertext bit (core cipher_out)
//   bit_valid   qualifies bit_in (core valid)
//   byte_out    current output byte; 0 while collecting
//   byte_valid  byte_out holds a valid byte (high during DRAIN)
//   byte_ready  consumer accepts the byte when byte_valid is also high
//   busy        high during DRAIN
//   overrun     sticky; a bit arrived while a block was still draining
module simon_out_collector #(
    parameter int unsigned BLOCK_BITS = 64,
    parameter int unsigned BYTE_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned NBYTES = BLOCK_BITS / BYTE_W;
    localparam int unsigned BCNT_W = (BLOCK_BITS > 1) ? $clog2(BLOCK_BITS) : 1;
    localparam int unsigned BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(BLOCK_BITS - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [BLOCK_BITS-1:0] blk;
    logic [BCNT_W-1:0]     bcnt;
    logic [BIDX_W-1:0]     bidx;

    logic last_bit;
    logic last_xfer;

    assign last_bit  = bit_valid && (bcnt == LAST_BIT);
    assign last_xfer = byte_ready && (bidx == LAST_BYTE);

    always_comb begin
        state_n = state;
        case (state)
            COLLECT: if (last_bit)  state_n = DRAIN;
            DRAIN:   if (last_xfer) state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= COLLECT;
            blk     <= '0;
            bcnt    <= '0;
            bidx    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                COLLECT: begin
                    if (bit_valid) begin
                        // Shift in at the MSB so the first bit ends at blk[0].
                        blk <= {bit_in, blk[BLOCK_BITS-1:1]};
                        if (last_bit) begin
                            bcnt <= '0;
                            bidx <= '0;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Bits arriving now are dropped; blk/bcnt stay untouched.
                    if (bit_valid) overrun <= 1'b1;
                    if (byte_ready) begin
                        bidx <= last_xfer ? '0 : bidx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_valid = (state == DRAIN);
    assign busy       = (state == DRAIN);

    always_comb begin
        byte_out = '0;
        if (state == DRAIN) byte_out = blk[int'(bidx) * BYTE_W +: BYTE_W];
    end

endmodule
